// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register with burst serializer:
// IDLE-mode operation codes and the burst controller state encoding.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst serializer controller: sequences a load followed by WIDTH right shifts,
// drives the busy flag and a one-cycle done pulse, and tells the datapath
// when to load or shift. A synchronous clear (inz) abandons any burst.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic Re,
    input  logic inz,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load_en,
    output logic shift_en
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             busy_next;
    logic             done_next;

    // State, bit counter and the registered handshake flags.
    always_ff @(posedge clk or negedge Re) begin
        if (!Re) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Next-state logic; the shift that sees cnt==1 is the last one, so the
    // counter stops at zero and never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_next  = busy;
        done_next  = 1'b0;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        if (inz) begin
            state_next = IDLE;
            cnt_next   = '0;
            busy_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load_en    = 1'b1;
                        cnt_next   = CNT_W'(WIDTH);
                        busy_next  = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    shift_en = 1'b1;
                    cnt_next = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/usr_shift_burst.sv
// Parametrised universal shift register with rotate, parallel load, serial
// output and a burst serializer that shifts a loaded word out LSB-first.
// Optional feature macro: USR_PARITY_EN adds a registered even-parity output
// of the register contents.
module usr_shift_burst
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             Re,
    input  logic             inz,
    input  logic [2:0]       mode,
    input  logic             sIn,
    input  logic [WIDTH-1:0] pIn,
    input  logic             start,
    output logic [WIDTH-1:0] Q,
    output logic             sOut,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic             load_en;
    logic             shift_en;
    logic             mode_en;
    logic [WIDTH-1:0] q_next;

    usr_burst_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .Re       (Re),
        .inz      (inz),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .load_en  (load_en),
        .shift_en (shift_en)
    );

    // busy marks SHIFT and done marks DONE, so both low means IDLE; a start
    // request in IDLE outranks the mode operation.
    assign mode_en = !busy && !done && !start;

    // Register next value: clear beats burst, burst beats the mode decode.
    always_comb begin
        q_next = Q;
        if (inz) begin
            q_next = '0;
        end else if (load_en) begin
            q_next = pIn;
        end else if (shift_en) begin
            q_next = {sIn, Q[WIDTH-1:1]};
        end else if (mode_en) begin
            case (mode)
                MODE_HOLD: q_next = Q;
                MODE_SHR:  q_next = {sIn, Q[WIDTH-1:1]};
                MODE_SHL:  q_next = {Q[WIDTH-2:0], sIn};
                MODE_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
                MODE_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
                MODE_LOAD: q_next = pIn;
                default:   q_next = Q;
            endcase
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge Re) begin
        if (!Re) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

    // Serial output taps the LSB when data leaves to the right, else the MSB.
    assign sOut = (busy || (mode == MODE_SHR)) ? Q[0] : Q[WIDTH-1];

`ifdef USR_PARITY_EN
    // Parity tracks the value being written so it lines up with Q.
    always_ff @(posedge clk or negedge Re) begin
        if (!Re) begin
            parity <= 1'b0;
        end else begin
            parity <= ^q_next;
        end
    end
`endif

endmodule
